// File: rtl/cpu_bus.sv
// cpu_bus: shared CPU data bus. Selects one of LANES drivers onto bus_data
// with lowest-index priority. Flags multi-driver contention and keeps it in a
// sticky error bit. Registers the bus value each cycle for observation.
module cpu_bus #(
   parameter int unsigned LANES = 6,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LANES-1:0]       lane_select,
   input  logic [LANES*WIDTH-1:0] lane_data,
   input  logic                   err_clear,
   output logic [WIDTH-1:0]       bus_data,
   output logic                   bus_active,
   output logic [IDX_W-1:0]       driver_idx,
   output logic                   contention,
   output logic                   contention_sticky,
   output logic [WIDTH-1:0]       bus_q
);

   logic [WIDTH-1:0] bus_data_c;
   logic [IDX_W-1:0] driver_idx_c;
   logic             contention_c;
   logic [WIDTH-1:0] bus_q_q, bus_q_d;
   logic             sticky_q, sticky_d;

   // Priority mux: the lowest-index enabled lane wins; an idle bus reads as zero.
   always_comb begin
      logic found;
      bus_data_c   = '0;
      driver_idx_c = '0;
      found        = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (!found && lane_select[i]) begin
            found        = 1'b1;
            bus_data_c   = lane_data[i*WIDTH +: WIDTH];
            driver_idx_c = IDX_W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves a nonzero value only when two or more lanes drive.
   always_comb begin
      contention_c = |(lane_select & (lane_select - LANES'(1)));
   end

   // Next state: snapshot the bus; sticky error sets on contention, set beats clear.
   always_comb begin
      bus_q_d  = bus_data_c;
      sticky_d = sticky_q;
      if (contention_c) begin
         sticky_d = 1'b1;
      end else if (err_clear) begin
         sticky_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_q_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         bus_q_q  <= bus_q_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus_data          = bus_data_c;
   assign bus_active        = |lane_select;
   assign driver_idx        = driver_idx_c;
   assign contention        = contention_c;
   assign contention_sticky = sticky_q;
   assign bus_q             = bus_q_q;

endmodule

// File: tb/tb_cpu_bus.sv
// tb_cpu_bus: directed scenarios plus randomized traffic against a behavioural bus model.
module tb_cpu_bus;

   localparam int unsigned LANES = 6;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned IDX_W = 3;

   logic                   clk;
   logic                   rst_n;
   logic [LANES-1:0]       lane_select;
   logic [LANES*WIDTH-1:0] lane_data;
   logic                   err_clear;
   logic [WIDTH-1:0]       bus_data;
   logic                   bus_active;
   logic [IDX_W-1:0]       driver_idx;
   logic                   contention;
   logic                   contention_sticky;
   logic [WIDTH-1:0]       bus_q;

   int n_checks;
   int n_pass;

   // Model state
   logic [WIDTH-1:0] m_bus;
   int               m_idx;
   logic             m_act;
   logic             m_con;
   logic [WIDTH-1:0] m_bus_q;
   logic             m_sticky;

   cpu_bus #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .lane_select       (lane_select),
      .lane_data         (lane_data),
      .err_clear         (err_clear),
      .bus_data          (bus_data),
      .bus_active        (bus_active),
      .driver_idx        (driver_idx),
      .contention        (contention),
      .contention_sticky (contention_sticky),
      .bus_q             (bus_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Bus rules stated arithmetically: isolate the lowest set bit, its log2 is the winner.
   task automatic model_comb();
      int unsigned sel, lsb;
      sel   = 32'(lane_select);
      m_act = (sel != 0);
      m_con = ($countones(sel) >= 2);
      if (m_act) begin
         lsb   = sel & (~sel + 1);
         m_idx = $clog2(lsb);
         m_bus = WIDTH'(lane_data >> (m_idx * WIDTH));
      end else begin
         m_idx = 0;
         m_bus = '0;
      end
   endtask

   task automatic check_comb(input string tag);
      model_comb();
      check({tag, ".bus_data"},   32'(bus_data),   32'(m_bus));
      check({tag, ".driver_idx"}, 32'(driver_idx), 32'(m_idx));
      check({tag, ".bus_active"}, 32'(bus_active), 32'(m_act));
      check({tag, ".contention"}, 32'(contention), 32'(m_con));
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".bus_q"},  32'(bus_q),             32'(m_bus_q));
      check({tag, ".sticky"}, 32'(contention_sticky), 32'(m_sticky));
   endtask

   // Drive inputs just after a falling edge and check the combinational outputs.
   task automatic apply(input logic [LANES-1:0] sel, input logic [LANES*WIDTH-1:0] data,
                        input logic clr, input string tag);
      @(negedge clk);
      lane_select = sel;
      lane_data   = data;
      err_clear   = clr;
      #1;
      check_comb(tag);
   endtask

   // Advance one rising edge, update the model, then check the registered outputs.
   task automatic tick(input string tag);
      model_comb();
      @(posedge clk);
      if (rst_n) begin
         m_bus_q = m_bus;
         if (m_con)          m_sticky = 1'b1;
         else if (err_clear) m_sticky = 1'b0;
      end
      #1;
      check_regs(tag);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      m_bus_q  = '0;
      m_sticky = 1'b0;
      #1;
      check_regs(tag);
      check_comb({tag, ".during"});
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [LANES*WIDTH-1:0] sweep_data();
      logic [LANES*WIDTH-1:0] d;
      d = '0;
      for (int i = 0; i < int'(LANES); i++) d[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
      return d;
   endfunction

   initial begin
      logic [LANES*WIDTH-1:0] d;
      logic [LANES-1:0]       s;
      n_checks = 0;
      n_pass   = 0;
      m_bus_q  = '0;
      m_sticky = 1'b0;

      // Reset with one lane selected: combinational path follows, registers held at zero.
      rst_n       = 1'b0;
      err_clear   = 1'b0;
      lane_select = 6'b000100;
      lane_data   = sweep_data();
      #3;
      check_regs("reset");
      check_comb("reset");
      check("reset.lane2", 32'(bus_data), 32'h12);
      release_reset();

      // Single driver sweep.
      for (int i = 0; i < int'(LANES); i++) begin
         apply(LANES'(1) << i, sweep_data(), 1'b0, "sweep");
         check("sweep.value", 32'(bus_data), 32'(8'h10 + i));
         tick("sweep");
         check("sweep.bus_q", 32'(bus_q), 32'(8'h10 + i));
      end

      // Idle bus pulls down even with all lanes at FF.
      apply('0, '1, 1'b0, "idle");
      check("idle.zero", 32'(bus_data), 32'h0);
      tick("idle");

      // Contention: lowest selected lane wins, sticky latches and holds.
      d = '1;
      d[1*WIDTH +: WIDTH] = 8'hA5;
      d[2*WIDTH +: WIDTH] = 8'h5A;
      apply(6'b100110, d, 1'b0, "contend");
      check("contend.value", 32'(bus_data), 32'hA5);
      tick("contend");
      check("contend.sticky", 32'(contention_sticky), 32'h1);
      apply(6'b000100, d, 1'b0, "onehot_after");
      tick("onehot_after");
      check("sticky.hold", 32'(contention_sticky), 32'h1);

      // Clear during contention is overridden, clear without contention works.
      apply(6'b000110, d, 1'b1, "clr_contend");
      tick("clr_contend");
      check("clr.set_wins", 32'(contention_sticky), 32'h1);
      apply(6'b000010, d, 1'b1, "clr");
      tick("clr");
      check("clr.cleared", 32'(contention_sticky), 32'h0);

      // Asynchronous reset mid-operation with contention persisting.
      d = '0;
      d[0 +: WIDTH] = 8'h33;
      apply(6'b000011, d, 1'b0, "pre_reset");
      tick("pre_reset");
      check("pre_reset.bus_q", 32'(bus_q), 32'h33);
      async_reset("async");
      check("async.bus_q0", 32'(bus_q), 32'h0);
      release_reset();
      #1;
      tick("post_release");
      check("post_release.resets", 32'(contention_sticky), 32'h1);

      // Randomized traffic with occasional clears and resets.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       s = '0;
            1:       s = LANES'(1) << $urandom_range(0, LANES - 1);
            default: s = LANES'($urandom);
         endcase
         d = {16'($urandom), 32'($urandom)};
         apply(s, d, 1'($urandom_range(0, 3) == 0), "rand");
         if ($urandom_range(0, 49) == 0) begin
            async_reset("rand_rst");
            release_reset();
            #1;
         end
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
